// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared types and glyph table for seven-segment capture/decode
package seven_segment_pkg;

  typedef logic [3:0] hex_digit_t;
  typedef logic [6:0] seg_pattern_t;

  localparam seg_pattern_t SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; index is the hex value the glyph represents.
  localparam seg_pattern_t SEG_GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seven_segment_capture_if.sv
// rtl/seven_segment_capture_if.sv - display lines and recovered-digit outputs of the capture block
interface seven_segment_capture_if;
  import seven_segment_pkg::*;

  logic [3:0]   an;
  seg_pattern_t seg;
  hex_digit_t   digit0;
  hex_digit_t   digit1;
  hex_digit_t   digit2;
  hex_digit_t   digit3;
  logic [3:0]   digit_valid;
  logic         digit_strobe;
  logic         frame_valid;
  logic         pattern_err;
  logic         an_err;

  // master is the display driver side, slave is the capture block
  modport master (
    output an, seg,
    input  digit0, digit1, digit2, digit3, digit_valid,
    input  digit_strobe, frame_valid, pattern_err, an_err
  );

  modport slave (
    input  an, seg,
    output digit0, digit1, digit2, digit3, digit_valid,
    output digit_strobe, frame_valid, pattern_err, an_err
  );

endinterface

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational segment pattern to hex lookup
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  seg_pattern_t seg,
  output logic         legal,
  output hex_digit_t   value
);

  always_comb begin
    legal = 1'b0;
    value = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPHS[i]) begin
        legal = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - samples multiplexed an/seg lines and recovers four hex digits
// Optional stale-digit timeout: SEVEN_SEGMENT_CAPTURE_STALE_TIMEOUT_EN
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
)(
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  seven_segment_capture_if.slave  cap
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

  logic [3:0]    an_q;
  seg_pattern_t  seg_q;
  logic [CW-1:0] stable_cnt;
  logic          captured;
  hex_digit_t    digit_r [4];
  logic [3:0]    valid_r;
  logic [3:0]    seen_r;
  logic          strobe_r;
  logic          frame_r;
  logic          pattern_err_r;
  logic          an_err_r;

  logic          glyph_legal;
  hex_digit_t    glyph_value;

  logic          changed;
  logic [CW-1:0] cnt_inc;
  logic          settled;
  logic [3:0]    an_low;
  logic          an_blank;
  logic          an_multi;
  logic [1:0]    hot_idx;
  logic [3:0]    hot_mask;
  logic [3:0]    capture_mask;
  logic [3:0]    stale_clr;
  logic [3:0]    seen_base;
  logic [3:0]    seen_next;

  seven_segment_decode u_decode (
    .seg   (seg_q),
    .legal (glyph_legal),
    .value (glyph_value)
  );

  // A change is detected on the edge that would load a different value into
  // an_q/seg_q, so the counter tracks how long the registered pair has held.
  always_comb begin
    changed  = ({cap.an, cap.seg} != {an_q, seg_q});
    cnt_inc  = (stable_cnt == SETTLE_MAX) ? SETTLE_MAX : stable_cnt + 1'b1;
    settled  = !changed && (cnt_inc == SETTLE_MAX) && !captured;
    an_low   = ~an_q;
    an_blank = (an_low == 4'b0000);
    an_multi = ((an_low & (an_low - 4'd1)) != 4'b0000);
  end

  always_comb begin
    hot_idx = 2'd0;
    case (an_low)
      4'b0010: hot_idx = 2'd1;
      4'b0100: hot_idx = 2'd2;
      4'b1000: hot_idx = 2'd3;
      default: hot_idx = 2'd0;
    endcase
    hot_mask     = 4'b0001 << hot_idx;
    capture_mask = (settled && !an_blank && !an_multi && glyph_legal) ? hot_mask : 4'b0000;
  end

`ifdef SEVEN_SEGMENT_CAPTURE_STALE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] refresh_cnt [4];

  // Counters saturate so an expired digit is invalidated only once.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) refresh_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (capture_mask[i])
          refresh_cnt[i] <= '0;
        else if (refresh_cnt[i] != TIMEOUT_MAX)
          refresh_cnt[i] <= refresh_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stale_clr = 4'b0000;
    for (int i = 0; i < 4; i++)
      stale_clr[i] = (refresh_cnt[i] == TIMEOUT_MAX - 1'b1) && !capture_mask[i];
  end
`else
  always_comb stale_clr = 4'b0000;
`endif

  always_comb begin
    seen_base = seen_r & ~stale_clr;
    seen_next = seen_base | hot_mask;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      an_q          <= 4'hF;
      seg_q         <= SEG_BLANK;
      stable_cnt    <= '0;
      captured      <= 1'b0;
      for (int i = 0; i < 4; i++) digit_r[i] <= '0;
      valid_r       <= 4'b0000;
      seen_r        <= 4'b0000;
      strobe_r      <= 1'b0;
      frame_r       <= 1'b0;
      pattern_err_r <= 1'b0;
      an_err_r      <= 1'b0;
    end else begin
      an_q          <= cap.an;
      seg_q         <= cap.seg;
      strobe_r      <= 1'b0;
      frame_r       <= 1'b0;
      pattern_err_r <= 1'b0;
      an_err_r      <= 1'b0;
      valid_r       <= valid_r & ~stale_clr;
      seen_r        <= seen_base;

      if (changed) begin
        stable_cnt <= '0;
        captured   <= 1'b0;
      end else begin
        stable_cnt <= cnt_inc;
        if (settled) captured <= 1'b1;
      end

      // One decision per stable window; a blank anode vector is ignored.
      if (settled && !an_blank) begin
        if (an_multi) begin
          an_err_r <= 1'b1;
        end else if (glyph_legal) begin
          digit_r[hot_idx] <= glyph_value;
          valid_r[hot_idx] <= 1'b1;
          strobe_r         <= 1'b1;
          if (seen_next == 4'b1111) begin
            frame_r <= 1'b1;
            seen_r  <= 4'b0000;
          end else begin
            seen_r  <= seen_next;
          end
        end else begin
          pattern_err_r    <= 1'b1;
          valid_r[hot_idx] <= 1'b0;
        end
      end
    end
  end

  assign cap.digit0       = digit_r[0];
  assign cap.digit1       = digit_r[1];
  assign cap.digit2       = digit_r[2];
  assign cap.digit3       = digit_r[3];
  assign cap.digit_valid  = valid_r;
  assign cap.digit_strobe = strobe_r;
  assign cap.frame_valid  = frame_r;
  assign cap.pattern_err  = pattern_err_r;
  assign cap.an_err       = an_err_r;

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - directed and randomized checks of seven_segment_capture
module tb_seven_segment_capture;

  localparam int SETTLE = 4;

  logic CLK100MHZ = 1'b0;
  logic reset;

  always #5 CLK100MHZ = ~CLK100MHZ;

  seven_segment_capture_if bus();

  seven_segment_capture #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (1_000_000)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .cap       (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: recovered digits, valid flags, seen mask and the pulse
  // vector {digit_strobe, frame_valid, pattern_err, an_err} for this cycle.
  logic [3:0] m_digit [4];
  logic [3:0] m_valid;
  logic [3:0] m_seen;
  logic [3:0] m_pulse;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_digit[i] = 4'h0;
    m_valid = 4'b0000;
    m_seen  = 4'b0000;
    m_pulse = 4'b0000;
  endtask

  task automatic model_event(input logic [3:0] a, input logic [6:0] s);
    int zeros = 0;
    int idx = 0;
    int g = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; idx = i; end
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == s) g = i;
    if (zeros > 1) begin
      m_pulse[0] = 1'b1;
    end else if (zeros == 1) begin
      if (g >= 0) begin
        m_digit[idx] = 4'(g);
        m_valid[idx] = 1'b1;
        m_seen[idx]  = 1'b1;
        m_pulse[3]   = 1'b1;
        if (m_seen == 4'b1111) begin
          m_pulse[2] = 1'b1;
          m_seen     = 4'b0000;
        end
      end else begin
        m_pulse[1]   = 1'b1;
        m_valid[idx] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0]  obs_p;
    logic [19:0] obs_s;
    logic [19:0] exp_s;
    obs_p = {bus.digit_strobe, bus.frame_valid, bus.pattern_err, bus.an_err};
    obs_s = {bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.digit_valid};
    exp_s = {m_digit[3], m_digit[2], m_digit[1], m_digit[0], m_valid};
    checks++;
    assert (obs_p === m_pulse) else begin
      errors++;
      $error("FAIL %s pulses observed=%b expected=%b", tag, obs_p, m_pulse);
    end
    checks++;
    assert (obs_s === exp_s) else begin
      errors++;
      $error("FAIL %s digits/valid observed=%h expected=%h", tag, obs_s, exp_s);
    end
  endtask

  // Drive a new an/seg pair and hold it n cycles; a stable window produces
  // its single event SETTLE+1 cycles after the inputs change.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input string tag);
    bus.an  = a;
    bus.seg = s;
    for (int j = 1; j <= n; j++) begin
      @(posedge CLK100MHZ);
      #1;
      m_pulse = 4'b0000;
      if (j == SETTLE + 1) model_event(a, s);
      check_outputs(tag);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(posedge CLK100MHZ);
      #1;
      model_clear();
      check_outputs("reset");
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] la;
    logic [3:0] onehot;
    logic [6:0] s;
    logic [6:0] ls;
    int r;

    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    reset   = 1'b1;
    model_clear();
    do_reset(3);

    hold(4'b1110, 7'b0110000, 8, "latency_digit0_3");

    hold(4'b1110, glyph_tab[1],  6, "frame_d0");
    hold(4'b1101, glyph_tab[2],  6, "frame_d1");
    hold(4'b1011, glyph_tab[10], 6, "frame_d2");
    hold(4'b0111, glyph_tab[15], 6, "frame_d3");

    hold(4'b1101, glyph_tab[5], 3, "glitch_d1");
    hold(4'b1011, glyph_tab[7], 6, "after_glitch_d2");

    hold(4'b1101, 7'b1111111, 6, "illegal_d1");
    hold(4'b1100, glyph_tab[8], 6, "multi_anode");
    hold(4'b1111, glyph_tab[8], 6, "blank_anode");

    hold(4'b0111, 7'b0000000, 2, "pre_reset_window");
    do_reset(1);
    hold(4'b0111, 7'b0000000, 7, "post_reset_capture");

    la = 4'b0111;
    ls = 7'b0000000;
    for (int k = 0; k < 150; k++) begin
      do begin
        r = $urandom_range(0, 9);
        onehot = 4'b0001 << $urandom_range(0, 3);
        if (r < 6)      a = ~onehot;
        else if (r < 8) a = 4'($urandom);
        else            a = 4'hF;
        if ($urandom_range(0, 2) != 0) s = glyph_tab[$urandom_range(0, 15)];
        else                           s = 7'($urandom);
      end while ({a, s} == {la, ls});
      hold(a, s, $urandom_range(1, 8), "random");
      la = a;
      ls = s;
      if ($urandom_range(0, 40) == 0) do_reset(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the four-digit multiplexed seven-segment driver.
- Samples the active-low anode strobes and segment lines, waits for them to settle, and decodes each segment pattern back to a 4-bit hex value.
- Holds the four recovered digits and flags complete frames and illegal patterns.
- Used as an on-board loopback checker and as a bench monitor for display-driving testers.

Parameters:
- SETTLE_CYCLES, 4, consecutive stable cycles of an/seg required before a sample is taken (minimum 1).
- TIMEOUT_CYCLES, 1_000_000, cycles without a refresh before a digit goes stale (used only with the optional feature).

Ports:
- CLK100MHZ  input  1  system clock
- reset  input  1  synchronous, active-high reset
- an  input  4  anode strobes, active-low; an[i]=0 selects digit i (digit 0 = rightmost)
- seg  input  7  segments, active-low; seg[0]=a … seg[6]=g
- digit0..digit3  output  4 each  last decoded value per digit
- digit_valid  output  4  per-digit valid flags
- digit_strobe  output  1  one-cycle pulse on each successful capture
- frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last frame
- pattern_err  output  1  one-cycle pulse when a settled pattern is not a legal hex glyph
- an_err  output  1  one-cycle pulse when a settled anode vector has more than one bit low

Behaviour:
- Reset values: digits=0, digit_valid=0, all pulses=0, seen mask=0, stable counter=0, captured flag=0.
- Input stage: an and seg are registered once (an_q, seg_q). All decisions use the registered values.
- Stability counter:
  - Clears whenever {an_q, seg_q} differs from its previous-cycle value; otherwise increments, saturating at SETTLE_CYCLES.
  - A change also clears the captured flag.
- Settled event: counter reaches SETTLE_CYCLES and captured flag is 0. Set the captured flag, so there is exactly one event per stable window.
- Settled event with an_q all ones: blank, no action.
- Settled event with an_q having more than one zero: an_err pulse; no state change.
- Settled event with an_q one-hot low at index i, seg_q a legal glyph:
  - digit_i <= decoded value; digit_valid[i] <= 1; seen[i] <= 1.
  - digit_strobe pulses on the same edge.
- Settled event with an_q one-hot low at index i, seg_q illegal:
  - pattern_err pulses; digit_valid[i] <= 0; digit_i and seen unchanged.
- Latency: with an/seg held constant from the cycle they first change, digit_strobe asserts SETTLE_CYCLES+1 cycles later.
- Frame detection:
  - When the seen mask including the current capture equals 1111, frame_valid pulses on the same edge as digit_strobe and seen clears to 0000.
  - Re-capturing a digit already marked in seen is allowed and does not produce a frame.
- Glyph table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is illegal.
- Reset asserted mid-window: all state returns to reset values on the next edge; any pending capture is discarded.

Optional Feature:
- Macro: SEVEN_SEGMENT_CAPTURE_STALE_TIMEOUT_EN.
- Defined:
  - Each digit has a refresh counter that clears on capture of that digit.
  - On reaching TIMEOUT_CYCLES, digit_valid[i] <= 0 and seen[i] <= 0; the digit value is kept.
- Undefined: no counters; digit_valid bits persist until overwritten by an illegal pattern or reset.

Decomposition:
- Package seven_segment_pkg:
  - Typedef hex_digit_t (logic [3:0]) and seg_pattern_t (logic [6:0]).
  - Constant array SEG_GLYPHS[16] holding the table above.
  - Constant SEG_BLANK = 7'b1111111.
- Sub-module seven_segment_decode: combinational seg_pattern_t -> {legal, hex_digit_t} lookup against SEG_GLYPHS. It is shared with any future display-checking logic.

Test Plan (SETTLE_CYCLES=4):
- Reset, then hold an=1110, seg=0110000 -> digit_strobe exactly 5 cycles after the change; digit0=3, digit_valid=0001; strobe not repeated while inputs are held.
- Cycle an through 1110/1101/1011/0111 with glyphs 1, 2, A, F, each held 6 cycles -> digits 1, 2, A, F; frame_valid pulses once, on the fourth capture; seen clears.
- Glitch: an=1101 for 3 cycles, then an=1011 held -> no capture of digit1; digit2 captured.
- Settled an=1101 with seg=1111111 -> pattern_err pulse; digit_valid[1] cleared; digit1 keeps its old value.
- Settled an=1100 -> an_err pulse; no digit change. Settled an=1111 -> no pulses at all.
- Reset asserted 2 cycles into a stable window with an=0111, seg=0000000 -> outputs all zero; no strobe. After reset deasserts with inputs held, a capture of 8 follows after 5 cycles.
